// File: rtl/clk_en_reset_gen.sv
// Clock-enable and core-reset generator: PLL lock sequencing, pixel/CPU dividers
// and a fractional sound-enable accumulator, all in the clk_sys domain.
module clk_en_reset_gen #(
    parameter int PIX_DIV  = 12,
    parameter int SND_NUM  = 3579545,
    parameter int SND_DEN  = 73728000,
    parameter int HOLD_CYC = 1024
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic soft_reset,
    input  logic pause,
    output logic sys_reset_n,
    output logic ce_pix,
    output logic ce_cpu,
    output logic ce_snd,
    output logic lock_lost
);

    // state     | meaning
    // WAIT_LOCK | PLL not locked (or soft reset held); core in reset, enables idle
    // HOLD      | locked; core still in reset while the hold timer runs out
    // RUN       | core released; enables running
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [7:0]  PIX_LAST  = 8'(PIX_DIV - 1);
    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);
    localparam logic [27:0] NUM       = 28'(SND_NUM);
    localparam logic [27:0] DEN       = 28'(SND_DEN);

    state_t      state;
    logic        sync_1;
    logic        locked_s;
    logic [15:0] hold_cnt;
    logic        hold_done;
    logic [7:0]  pix_cnt;
    logic        phase;
    logic [27:0] acc;

    logic [27:0] acc_sum;
    logic        snd_hit;
    logic        pix_wrap;
    logic        enter_hold;
    logic        active;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_1   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_1   <= pll_locked;
            locked_s <= sync_1;
        end
    end

    // acc and NUM are both below 2^27, so the sum cannot overflow 28 bits.
    always_comb begin
        acc_sum    = acc + NUM;
        snd_hit    = (acc_sum >= DEN);
        pix_wrap   = (pix_cnt == PIX_LAST);
        enter_hold = locked_s &&
                     (((state == WAIT_LOCK) && !soft_reset) ||
                      ((state == RUN) && soft_reset));
        active     = locked_s && !enter_hold && (state != WAIT_LOCK);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_LOCK;
            sys_reset_n <= 1'b0;
            hold_cnt    <= '0;
            hold_done   <= 1'b0;
            pix_cnt     <= '0;
            phase       <= 1'b0;
            acc         <= '0;
            ce_pix      <= 1'b0;
            ce_cpu      <= 1'b0;
            ce_snd      <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            ce_pix <= 1'b0;
            ce_cpu <= 1'b0;
            ce_snd <= 1'b0;
            if (!locked_s) begin
                state       <= WAIT_LOCK;
                sys_reset_n <= 1'b0;
                hold_cnt    <= '0;
                hold_done   <= 1'b0;
                pix_cnt     <= '0;
                phase       <= 1'b0;
                acc         <= '0;
                if (state == RUN) lock_lost <= 1'b1;
            end else if (enter_hold) begin
                state       <= HOLD;
                sys_reset_n <= 1'b0;
                hold_cnt    <= HOLD_LOAD;
                hold_done   <= 1'b0;
                pix_cnt     <= '0;
                phase       <= 1'b0;
                acc         <= '0;
            end else if (active) begin
                // hold_done adds the extra cycle after the timer reads zero
                if (state == HOLD) begin
                    if (soft_reset) begin
                        hold_cnt  <= HOLD_LOAD;
                        hold_done <= 1'b0;
                    end else if (hold_done) begin
                        state       <= RUN;
                        sys_reset_n <= 1'b1;
                        hold_done   <= 1'b0;
                    end else if (hold_cnt == '0) begin
                        hold_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                if (pix_wrap) begin
                    pix_cnt <= '0;
                    ce_pix  <= 1'b1;
                    phase   <= ~phase;
                    ce_cpu  <= phase && (state == RUN) && !pause;
                end else begin
                    pix_cnt <= pix_cnt + 8'd1;
                end
                if (snd_hit) begin
                    acc    <= acc_sum - DEN;
                    ce_snd <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_en_reset_gen.sv
// Directed bench for clk_en_reset_gen with PIX_DIV=12, SND_NUM/DEN=3/8, HOLD_CYC=4.
module tb_clk_en_reset_gen;

    logic clk_sys = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b1;
    logic soft_reset = 1'b0;
    logic pause = 1'b0;
    logic sys_reset_n, ce_pix, ce_cpu, ce_snd, lock_lost;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;

    clk_en_reset_gen #(
        .PIX_DIV (12),
        .SND_NUM (3),
        .SND_DEN (8),
        .HOLD_CYC(4)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .soft_reset (soft_reset),
        .pause      (pause),
        .sys_reset_n(sys_reset_n),
        .ce_pix     (ce_pix),
        .ce_cpu     (ce_cpu),
        .ce_snd     (ce_snd),
        .lock_lost  (lock_lost)
    );

    always #5 clk_sys = ~clk_sys;

    // cyc counts posedges since reset release; sampling happens on the negedge.
    task automatic tick();
        @(negedge clk_sys);
        cyc++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        vectors++; if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL reset_sys_reset_n got=%b exp=0", sys_reset_n); end
        vectors++; if ({ce_pix, ce_cpu, ce_snd} !== 3'b000) begin errors++; $display("FAIL reset_ce got=%b exp=000", {ce_pix, ce_cpu, ce_snd}); end
        vectors++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
        vectors++; if (dut.locked_s !== 1'b0) begin errors++; $display("FAIL reset_locked_s got=%b exp=0", dut.locked_s); end
    endtask

    task automatic test_lock_hold();
        int f_sys = -1, f_pix = -1, f_cpu = -1, f_snd = -1, n_pix = 0;
        logic ls1 = 1'bx, ls2 = 1'bx;
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            tick();
            if (cyc == 1) ls1 = dut.locked_s;
            if (cyc == 2) ls2 = dut.locked_s;
            if (sys_reset_n === 1'b1 && f_sys < 0) f_sys = cyc;
            if (ce_pix === 1'b1 && f_pix < 0) f_pix = cyc;
            if (ce_cpu === 1'b1 && f_cpu < 0) f_cpu = cyc;
            if (ce_snd === 1'b1 && f_snd < 0) f_snd = cyc;
            if (ce_pix === 1'b1) n_pix++;
        end
        vectors++; if (ls1 !== 1'b0) begin errors++; $display("FAIL sync_edge1 got=%b exp=0", ls1); end
        vectors++; if (ls2 !== 1'b1) begin errors++; $display("FAIL sync_edge2 got=%b exp=1", ls2); end
        vectors++; if (f_sys != 8) begin errors++; $display("FAIL hold_release_cycle got=%0d exp=8", f_sys); end
        vectors++; if (f_pix != 15) begin errors++; $display("FAIL first_ce_pix got=%0d exp=15", f_pix); end
        vectors++; if (f_cpu != 27) begin errors++; $display("FAIL first_ce_cpu got=%0d exp=27", f_cpu); end
        vectors++; if (f_snd != 6) begin errors++; $display("FAIL first_ce_snd got=%0d exp=6", f_snd); end
        vectors++; if (n_pix != 3) begin errors++; $display("FAIL ce_pix_count_40 got=%0d exp=3", n_pix); end
    endtask

    task automatic test_pause();
        int n_pix = 0, n_cpu = 0, bad_gap = 0, last_pix = 39, f_cpu = -1;
        pause = 1'b1;
        while (cyc < 140) begin
            tick();
            if (ce_cpu === 1'b1) n_cpu++;
            if (ce_pix === 1'b1) begin
                n_pix++;
                if (cyc - last_pix != 12) bad_gap++;
                last_pix = cyc;
            end
        end
        pause = 1'b0;
        while (cyc < 147) begin
            tick();
            if (ce_cpu === 1'b1 && f_cpu < 0) f_cpu = cyc;
        end
        vectors++; if (n_cpu != 0) begin errors++; $display("FAIL pause_ce_cpu_count got=%0d exp=0", n_cpu); end
        vectors++; if (n_pix != 8) begin errors++; $display("FAIL pause_ce_pix_count got=%0d exp=8", n_pix); end
        vectors++; if (bad_gap != 0) begin errors++; $display("FAIL pause_ce_pix_period bad_gaps=%0d exp=0", bad_gap); end
        vectors++; if (f_cpu != 147) begin errors++; $display("FAIL pause_resume_cpu got=%0d exp=147", f_cpu); end
        vectors++; if (ce_pix !== 1'b1) begin errors++; $display("FAIL pause_resume_coincident ce_pix=%b exp=1", ce_pix); end
    endtask

    task automatic test_lock_loss();
        int f_low = -1, f_rise = -1, f_pix = -1;
        logic ll149 = 1'bx, ll150 = 1'bx;
        logic [2:0] ce150 = 3'bxxx;
        pll_locked = 1'b0;
        while (cyc < 170) begin
            tick();
            if (cyc == 148) pll_locked = 1'b1;
            if (cyc == 149) ll149 = lock_lost;
            if (cyc == 150) begin ll150 = lock_lost; ce150 = {ce_pix, ce_cpu, ce_snd}; end
            if (sys_reset_n === 1'b0 && f_low < 0) f_low = cyc;
            if (f_low > 0 && sys_reset_n === 1'b1 && f_rise < 0) f_rise = cyc;
            if (cyc > 150 && ce_pix === 1'b1 && f_pix < 0) f_pix = cyc;
        end
        vectors++; if (f_low != 150) begin errors++; $display("FAIL lockloss_reset_cycle got=%0d exp=150", f_low); end
        vectors++; if (ll149 !== 1'b0) begin errors++; $display("FAIL lockloss_flag_early got=%b exp=0", ll149); end
        vectors++; if (ll150 !== 1'b1) begin errors++; $display("FAIL lockloss_flag_set got=%b exp=1", ll150); end
        vectors++; if (ce150 !== 3'b000) begin errors++; $display("FAIL lockloss_ce got=%b exp=000", ce150); end
        vectors++; if (f_rise != 156) begin errors++; $display("FAIL relock_release got=%0d exp=156", f_rise); end
        vectors++; if (f_pix != 163) begin errors++; $display("FAIL relock_first_pix got=%0d exp=163", f_pix); end
        vectors++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL lockloss_sticky got=%b exp=1", lock_lost); end
    endtask

    task automatic test_soft_reset();
        int f_rise = -1, f_snd = -1, n_snd = 0, f_cpu = -1;
        logic sr171 = 1'bx;
        soft_reset = 1'b1;
        while (cyc < 200) begin
            tick();
            if (cyc == 171) begin soft_reset = 1'b0; sr171 = sys_reset_n; end
            if (cyc == 173) soft_reset = 1'b1;
            if (cyc == 174) soft_reset = 1'b0;
            if (cyc > 171 && sys_reset_n === 1'b1 && f_rise < 0) f_rise = cyc;
            if (cyc >= 172 && cyc <= 185 && ce_snd === 1'b1) begin
                n_snd++;
                if (f_snd < 0) f_snd = cyc;
            end
            if (cyc > 171 && ce_cpu === 1'b1 && f_cpu < 0) f_cpu = cyc;
        end
        vectors++; if (sr171 !== 1'b0) begin errors++; $display("FAIL soft_assert got=%b exp=0", sr171); end
        vectors++; if (f_rise != 179) begin errors++; $display("FAIL soft_release got=%0d exp=179", f_rise); end
        vectors++; if (f_snd != 174) begin errors++; $display("FAIL soft_acc_kept_first got=%0d exp=174", f_snd); end
        vectors++; if (n_snd != 5) begin errors++; $display("FAIL soft_acc_kept_count got=%0d exp=5", n_snd); end
        vectors++; if (f_cpu != 195) begin errors++; $display("FAIL soft_first_cpu got=%0d exp=195", f_cpu); end
    endtask

    task automatic test_lock_and_soft();
        int f_rise = -1;
        logic [1:0] st203 = 2'bxx;
        logic sr203 = 1'bx;
        pll_locked = 1'b0;
        while (cyc < 215) begin
            tick();
            if (cyc == 201) pll_locked = 1'b1;
            if (cyc == 202) soft_reset = 1'b1;
            if (cyc == 203) begin soft_reset = 1'b0; st203 = 2'(dut.state); sr203 = sys_reset_n; end
            if (cyc > 203 && sys_reset_n === 1'b1 && f_rise < 0) f_rise = cyc;
        end
        vectors++; if (st203 !== 2'd0) begin errors++; $display("FAIL lock_priority_state got=%0d exp=0", st203); end
        vectors++; if (sr203 !== 1'b0) begin errors++; $display("FAIL lock_priority_reset got=%b exp=0", sr203); end
        vectors++; if (f_rise != 209) begin errors++; $display("FAIL lock_priority_release got=%0d exp=209", f_rise); end
    endtask

    task automatic test_snd();
        int n_snd = 0, n_adj = 0, n_big = 0, n_pix = 0, n_cpu = 0;
        logic prev = 1'b0;
        while (cyc < 1015) begin
            tick();
            if (ce_snd === 1'b1) begin
                n_snd++;
                if (prev) n_adj++;
            end
            prev = (ce_snd === 1'b1);
            if (dut.acc >= 28'd8) n_big++;
            if (ce_pix === 1'b1) n_pix++;
            if (ce_cpu === 1'b1) n_cpu++;
        end
        vectors++; if (n_snd != 300) begin errors++; $display("FAIL snd_count got=%0d exp=300", n_snd); end
        vectors++; if (n_adj != 0) begin errors++; $display("FAIL snd_adjacent got=%0d exp=0", n_adj); end
        vectors++; if (n_big != 0) begin errors++; $display("FAIL snd_acc_range got=%0d exp=0", n_big); end
        vectors++; if (n_pix != 67) begin errors++; $display("FAIL run_pix_count got=%0d exp=67", n_pix); end
        vectors++; if (n_cpu != 33) begin errors++; $display("FAIL run_cpu_count got=%0d exp=33", n_cpu); end
    endtask

    task automatic test_async_reset();
        @(posedge clk_sys);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (sys_reset_n !== 1'b0) begin errors++; $display("FAIL async_sys_reset_n got=%b exp=0", sys_reset_n); end
        vectors++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL async_lock_lost got=%b exp=0", lock_lost); end
        vectors++; if (dut.locked_s !== 1'b0) begin errors++; $display("FAIL async_locked_s got=%b exp=0", dut.locked_s); end
        vectors++; if ({ce_pix, ce_cpu, ce_snd} !== 3'b000) begin errors++; $display("FAIL async_ce got=%b exp=000", {ce_pix, ce_cpu, ce_snd}); end
    endtask

    initial begin
        test_reset();
        test_lock_hold();
        test_pause();
        test_lock_loss();
        test_soft_reset();
        test_lock_and_soft();
        test_snd();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/clk_en_reset_gen.md
CLK_EN_RESET_GEN -- requirements
Module: clk_en_reset_gen

Interface
REQ-001 Parameter PIX_DIV, default 12: clk_sys cycles per ce_pix pulse (73.728 MHz / 12 = 6.144 MHz); legal range 2..255.
REQ-002 Parameter SND_NUM, default 3579545: numerator of the fractional sound enable.
REQ-003 Parameter SND_DEN, default 73728000: denominator of the fractional sound enable; SND_NUM < SND_DEN and SND_DEN < 2^27 SHALL hold.
REQ-004 Parameter HOLD_CYC, default 1024: number of locked cycles before reset release; legal range 1..65535.
REQ-005 Port clk_sys, input, 1: 73.728 MHz system clock, taken from PLL outclk_0.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port pll_locked, input, 1: PLL lock flag, asynchronous to clk_sys.
REQ-008 Port soft_reset, input, 1: synchronous level reset request from the OSD/HPS.
REQ-009 Port pause, input, 1: synchronous level; gates the CPU enable.
REQ-010 Port sys_reset_n, output, 1: registered active-low core reset.
REQ-011 Port ce_pix, output, 1: one-cycle pixel clock enable.
REQ-012 Port ce_cpu, output, 1: one-cycle CPU clock enable at half the ce_pix rate.
REQ-013 Port ce_snd, output, 1: one-cycle fractional sound clock enable.
REQ-014 Port lock_lost, output, 1: sticky flag set when lock drops while in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; locked_s is the second flop's output; all decisions below SHALL use locked_s only.
REQ-016 The FSM SHALL have three states: WAIT_LOCK, HOLD, RUN.
REQ-017 WAIT_LOCK->HOLD when locked_s=1 and soft_reset=0; on entry the hold counter loads HOLD_CYC-1, the pixel counter clears to 0, and the CPU phase bit clears to 0.
REQ-018 HOLD: the counter decrements each cycle; HOLD->RUN in the cycle after the counter reads 0, so sys_reset_n rises exactly HOLD_CYC+1 cycles after the HOLD entry edge.
REQ-019 HOLD with soft_reset=1: reload the counter to HOLD_CYC-1 and stay in HOLD.
REQ-020 RUN with soft_reset=1: go to HOLD with the REQ-017 entry actions.
REQ-021 Any state with locked_s=0: go to WAIT_LOCK; this transition SHALL take priority over soft_reset.
REQ-022 RUN->WAIT_LOCK through REQ-021 SHALL set lock_lost; lock_lost SHALL clear only on rst_n.
REQ-023 sys_reset_n SHALL be registered: 0 in WAIT_LOCK and HOLD, 1 only in RUN; it is deasserted synchronously and asserted on the first edge after leaving RUN.
REQ-024 Pixel counter (8 bit): active in HOLD and RUN; counts 0..PIX_DIV-1 and wraps; ce_pix SHALL be registered high for one cycle each time the counter holds PIX_DIV-1.
REQ-025 The CPU phase bit SHALL toggle on every ce_pix.
REQ-026 ce_cpu SHALL equal ce_pix AND phase=1 AND state=RUN AND pause=0 (registered, coincident with ce_pix): one pulse per 24 cycles, 3.072 MHz.
REQ-027 pause SHALL NOT stall the pixel counter, the phase bit, or the sound accumulator.
REQ-028 Sound accumulator (28 bit unsigned): active in HOLD and RUN.
REQ-029 Sound accumulator update: if acc+SND_NUM >= SND_DEN, then acc <= acc+SND_NUM-SND_DEN and ce_snd is registered 1; otherwise acc <= acc+SND_NUM and ce_snd is 0.
REQ-030 The accumulator SHALL clear to 0 on HOLD entry from WAIT_LOCK or RUN, and SHALL NOT clear on the HOLD self-reload of REQ-019.
REQ-031 Over SND_DEN consecutive active cycles, exactly SND_NUM ce_snd pulses SHALL occur, with no two pulses adjacent.
REQ-032 In WAIT_LOCK, ce_pix, ce_cpu and ce_snd SHALL be 0 and all counters SHALL hold 0.

Reset
REQ-033 While rst_n=0: state=WAIT_LOCK, synchronizer flops=0, all counters=0, acc=0, phase=0, sys_reset_n=0, ce_pix=0, ce_cpu=0, ce_snd=0, lock_lost=0.
REQ-034 rst_n assertion SHALL take effect asynchronously; removal is synchronized by the system-level reset bridge; the first FSM action occurs on the edge after removal.

Verification
REQ-035 Scenario: rst_n release, pll_locked=1 steady, HOLD_CYC=4 -> locked_s high after 2 edges; sys_reset_n rises 5 cycles after HOLD entry; ce_pix first pulse 12 cycles after HOLD entry; ce_cpu first pulse on the 2nd ce_pix occurring in RUN.
REQ-036 Scenario: in RUN, pause=1 for 100 cycles -> ce_cpu=0 throughout; ce_pix keeps its 12-cycle period; ce_cpu resumes on the next phase=1 ce_pix after pause drops.
REQ-037 Scenario: in RUN, pll_locked drops 1 cycle -> WAIT_LOCK within 3 edges; sys_reset_n=0; all ce=0; lock_lost=1 and stays 1 through relock and RUN.
REQ-038 Scenario: soft_reset pulsed in RUN, then re-pulsed mid-HOLD -> sys_reset_n=0; release occurs HOLD_CYC+1 cycles after the last pulse; acc is not cleared by the second pulse.
REQ-039 Scenario: pll_locked fall and soft_reset=1 in the same cycle -> WAIT_LOCK (not HOLD).
REQ-040 Scenario: SND_NUM=3, SND_DEN=8, 800 active cycles -> exactly 300 ce_snd pulses; acc never >= 8; no back-to-back pulses.
